sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 23, SDRAM word-address width.
REQ-002 Parameter LEN_W, default 9, FIFO fill-level and burst-length width.
REQ-003 Parameter BURST_LEN, default 128, words per burst; SHALL be less than 2**(LEN_W-1).
REQ-004 clock  input  1  sole clock; all logic rising-edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 wr_fill, rd1_fill, rd2_fill  input  LEN_W each  fill levels of write FIFO and read FIFOs 1 and 2.
REQ-007 wr_base/wr_max, rd1_base/rd1_max, rd2_base/rd2_max  input  ADDR_W each  per-port start and end address; quasi-static.
REQ-008 load  input  1  restart all port addresses at their base.
REQ-009 cmd_valid  output  1  burst command offered to the SDRAM engine.
REQ-010 cmd_ready  input  1  engine accepts the command.
REQ-011 cmd_write  output  1  1 = write burst, 0 = read burst.
REQ-012 cmd_port  output  2  0 = write, 1 = rd1, 2 = rd2.
REQ-013 cmd_addr  output  ADDR_W  burst start address.
REQ-014 cmd_len  output  LEN_W  constant BURST_LEN.
REQ-015 cmd_done  input  1  one-cycle pulse when the accepted burst completes.
REQ-016 busy  output  1  high in ISSUE and BUSY states.

Function
REQ-017 Request conditions: write when wr_fill >= BURST_LEN; rdN when rdN_fill < BURST_LEN.
REQ-018 FSM states: IDLE, ISSUE, BUSY.
REQ-019 IDLE: when any request is asserted, latch the winner and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-020 Priority: write > rd1 > rd2 (fixed priority unless REQ-030 applies).
REQ-021 ISSUE: assert cmd_valid with cmd_write/cmd_port/cmd_addr stable; go to BUSY on the cycle cmd_valid && cmd_ready.
REQ-022 cmd_valid, once asserted, SHALL NOT drop, and command fields SHALL NOT change, until accepted.
REQ-023 BUSY: wait for cmd_done, then go to IDLE; minimum one IDLE cycle between bursts.
REQ-024 cmd_done outside BUSY SHALL be ignored.
REQ-025 Address update on cmd_done for the granted port: next = addr + BURST_LEN; if next + BURST_LEN > max then next = base.
REQ-026 load in IDLE: all three address registers take their base value next cycle.
REQ-027 load in ISSUE or BUSY: set load_pending; apply it at cmd_done, overriding that port's increment; clear it on the same cycle.
REQ-028 All outputs registered; request-to-cmd_valid latency is 2 cycles from IDLE.

Reset
REQ-029 While aresetn=0 at a clock edge, all of the following take effect:
- state=IDLE.
- cmd_valid=0, cmd_write=0, cmd_port=0, cmd_addr=0, busy=0.
- cmd_len=BURST_LEN.
- Address registers = respective base.
- load_pending=0.
- Round-robin pointer = rd1.
- An in-flight burst is abandoned; no address is updated for it.

Configuration
REQ-030 Macro ARB_READ_RR_EN defined:
- Write keeps top priority.
- rd1 and rd2 alternate: a 1-bit pointer flips to the other read port after each granted read.
REQ-031 Macro undefined: fixed priority per REQ-020; pointer logic absent.

Structure
REQ-032 Shared package sdram_arb_pkg SHALL hold:
- State encoding: IDLE, ISSUE, BUSY.
- Port-ID constants: PORT_WR=0, PORT_RD1=1, PORT_RD2=2.
REQ-033 One sub-module, arb_addr_gen, instantiated three times, SHALL hold one port's address register with base/max wrap and load handling.

Verification
REQ-034 Bench SHALL cover the following directed scenarios (defaults unless stated):
- wr_fill=128, rd fills=200, base 0, max 153600 -> cmd_valid two cycles later with write=1, port=0, addr=0; after done, next write addr=128.
- wr_fill=128 and rd1_fill=0 simultaneously -> write granted first, rd1 granted on the next arbitration.
- rd1_fill=rd2_fill=0 held, 4 bursts, macro on -> ports 1,2,1,2; macro off -> 1,1,1,1.
- rd1_base=8320, rd1_max=8576 -> addresses 8320, 8448, 8320 (wrap).
- load during BUSY at write addr 256 -> after done, write addr = wr_base, not 384.
- cmd_ready held low 10 cycles -> cmd_valid and all fields stable for 10 cycles.
- aresetn low mid-BUSY -> next cycle cmd_valid=0, busy=0; addresses at base.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM state encoding and port IDs.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam logic [1:0] PORT_WR  = 2'd0;
  localparam logic [1:0] PORT_RD1 = 2'd1;
  localparam logic [1:0] PORT_RD2 = 2'd2;

endpackage

// File: rtl/arb_addr_gen.sv
// One port's burst address register: advances by BURST_LEN per completed burst and
// wraps to base when the following burst would run past max.
module arb_addr_gen #(
  parameter int ADDR_W    = 23,
  parameter int BURST_LEN = 128
) (
  input  logic              clock,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] max,
  input  logic              restart,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  localparam int W = ADDR_W + 2;

  logic [ADDR_W-1:0] next_addr;
  logic              wrap;

  // Extra headroom bits so the end-of-next-burst compare cannot overflow.
  assign next_addr = addr + ADDR_W'(BURST_LEN);
  assign wrap      = (W'(addr) + W'(2 * BURST_LEN)) > W'(max);

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      addr <= base;
    end else if (restart) begin
      addr <= base;
    end else if (advance) begin
      addr <= wrap ? base : next_addr;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates one write and two read FIFOs onto a single SDRAM burst engine.
// Define ARB_READ_RR_EN to alternate between the read ports instead of fixed priority.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int LEN_W     = 9,
  parameter int BURST_LEN = 128
) (
  input  logic              clock,
  input  logic              aresetn,
  input  logic [LEN_W-1:0]  wr_fill,
  input  logic [LEN_W-1:0]  rd1_fill,
  input  logic [LEN_W-1:0]  rd2_fill,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] wr_max,
  input  logic [ADDR_W-1:0] rd1_base,
  input  logic [ADDR_W-1:0] rd1_max,
  input  logic [ADDR_W-1:0] rd2_base,
  input  logic [ADDR_W-1:0] rd2_max,
  input  logic              load,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [1:0]        cmd_port,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              busy
);

  arb_state_t        state, next_state;
  logic              wr_req, rd1_req, rd2_req, any_req;
  logic [1:0]        win_port;
  logic [ADDR_W-1:0] win_addr;
  logic              load_pending;
  logic              done_ok;
  logic              restart_all;
  logic [ADDR_W-1:0] port_addr [3];
  logic [ADDR_W-1:0] port_base [3];
  logic [ADDR_W-1:0] port_max  [3];

  assign wr_req  = wr_fill  >= LEN_W'(BURST_LEN);
  assign rd1_req = rd1_fill <  LEN_W'(BURST_LEN);
  assign rd2_req = rd2_fill <  LEN_W'(BURST_LEN);
  assign any_req = wr_req || rd1_req || rd2_req;

  assign port_base[0] = wr_base;
  assign port_base[1] = rd1_base;
  assign port_base[2] = rd2_base;
  assign port_max[0]  = wr_max;
  assign port_max[1]  = rd1_max;
  assign port_max[2]  = rd2_max;

  assign done_ok     = (state == BUSY) && cmd_done;
  assign restart_all = ((state == IDLE) && load) || (done_ok && (load_pending || load));

  for (genvar p = 0; p < 3; p++) begin : g_addr
    arb_addr_gen #(
      .ADDR_W   (ADDR_W),
      .BURST_LEN(BURST_LEN)
    ) u_addr_gen (
      .clock  (clock),
      .aresetn(aresetn),
      .base   (port_base[p]),
      .max    (port_max[p]),
      .restart(restart_all),
      .advance(done_ok && (cmd_port == 2'(p))),
      .addr   (port_addr[p])
    );
  end

`ifdef ARB_READ_RR_EN
  logic rr_ptr;

  always_comb begin
    win_port = PORT_RD2;
    if (wr_req)                  win_port = PORT_WR;
    else if (rd1_req && rd2_req) win_port = rr_ptr ? PORT_RD2 : PORT_RD1;
    else if (rd1_req)            win_port = PORT_RD1;
  end

  // rr_ptr = 0 prefers rd1; it points away from whichever read port was just granted.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      rr_ptr <= 1'b0;
    end else if ((state == IDLE) && any_req && (win_port != PORT_WR)) begin
      rr_ptr <= (win_port == PORT_RD1);
    end
  end
`else
  always_comb begin
    win_port = PORT_RD2;
    if (wr_req)       win_port = PORT_WR;
    else if (rd1_req) win_port = PORT_RD1;
  end
`endif

  // A load arriving alongside a grant means the burst must start at the port's base.
  always_comb begin
    win_addr = load ? port_base[0] : port_addr[0];
    case (win_port)
      PORT_RD1: win_addr = load ? port_base[1] : port_addr[1];
      PORT_RD2: win_addr = load ? port_base[2] : port_addr[2];
      default:  ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req)                 next_state = ISSUE;
      ISSUE:   if (cmd_valid && cmd_ready)  next_state = BUSY;
      BUSY:    if (cmd_done)                next_state = IDLE;
      default:                              next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state        <= IDLE;
      cmd_valid    <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_port     <= 2'd0;
      cmd_addr     <= '0;
      cmd_len      <= LEN_W'(BURST_LEN);
      busy         <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != IDLE);
      cmd_len   <= LEN_W'(BURST_LEN);
      cmd_valid <= (state == ISSUE) && !(cmd_valid && cmd_ready);
      if ((state == IDLE) && any_req) begin
        cmd_port  <= win_port;
        cmd_write <= (win_port == PORT_WR);
        cmd_addr  <= win_addr;
      end
      if (done_ok)
        load_pending <= 1'b0;
      else if ((state != IDLE) && load)
        load_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed table, corner sequences, and
// randomized bursts checked against a behavioural address/grant model.
module tb_sdram_port_arbiter;

  localparam int BL = 128;

  logic        clock = 1'b0;
  logic        aresetn;
  logic [8:0]  wr_fill, rd1_fill, rd2_fill;
  logic [22:0] wr_base, wr_max, rd1_base, rd1_max, rd2_base, rd2_max;
  logic        load;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_done, busy;
  logic [1:0]  cmd_port;
  logic [22:0] cmd_addr;
  logic [8:0]  cmd_len;

  int checks   = 0;
  int failures = 0;

  longint m_addr [3];
  longint m_base [3];
  longint m_max  [3];
  int     prefer;

  typedef struct {
    int     wr, rd1, rd2;
    bit     load_busy;
    int     ready_dly;
    int     exp_port;
    longint exp_addr;
  } vec_t;

  vec_t vecs [8];

  always #5 clock = ~clock;

  sdram_port_arbiter dut (
    .clock    (clock),
    .aresetn  (aresetn),
    .wr_fill  (wr_fill),
    .rd1_fill (rd1_fill),
    .rd2_fill (rd2_fill),
    .wr_base  (wr_base),
    .wr_max   (wr_max),
    .rd1_base (rd1_base),
    .rd1_max  (rd1_max),
    .rd2_base (rd2_base),
    .rd2_max  (rd2_max),
    .load     (load),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_port (cmd_port),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_done (cmd_done),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int w, input int r1, input int r2);
    wr_fill  = 9'(w);
    rd1_fill = 9'(r1);
    rd2_fill = 9'(r2);
  endtask

  task automatic driveBases();
    wr_base  = 23'(m_base[0]);  wr_max  = 23'(m_max[0]);
    rd1_base = 23'(m_base[1]);  rd1_max = 23'(m_max[1]);
    rd2_base = 23'(m_base[2]);  rd2_max = 23'(m_max[2]);
  endtask

  // Grant rule: write wins when its FIFO holds a full burst; reads want a burst when
  // their FIFO has room for one. Returns -1 when nobody asks.
  function automatic int modelGrant(input int w, input int r1, input int r2);
    bit wq = (w >= BL);
    bit q1 = (r1 < BL);
    bit q2 = (r2 < BL);
    int g;
    if (wq) return 0;
    if (!q1 && !q2) return -1;
`ifdef ARB_READ_RR_EN
    if (q1 && q2) g = prefer;
    else          g = q1 ? 1 : 2;
    prefer = (g == 1) ? 2 : 1;
`else
    g = q1 ? 1 : 2;
`endif
    return g;
  endfunction

  task automatic modelDone(input int g, input bit ld);
    longint nxt;
    if (ld) begin
      for (int p = 0; p < 3; p++) m_addr[p] = m_base[p];
    end else begin
      nxt = m_addr[g] + BL;
      if (nxt + BL > m_max[g]) nxt = m_base[g];
      m_addr[g] = nxt;
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < 3; p++) m_addr[p] = m_base[p];
    prefer = 1;
  endtask

  // One complete burst from an idle arbiter: grant, hold off ready, accept, complete.
  task automatic doBurst(input int w, input int r1, input int r2, input int exp_port,
                         input longint exp_addr, input int ready_dly, input int done_dly,
                         input bit load_busy);
    @(negedge clock);
    applyStimulus(w, r1, r2);
    @(negedge clock);
    checkOutput("valid_early", cmd_valid, 0);
    checkOutput("busy_issue", busy, 1);
    @(negedge clock);
    checkOutput("valid", cmd_valid, 1);
    checkOutput("port", cmd_port, exp_port);
    checkOutput("write", cmd_write, (exp_port == 0) ? 1 : 0);
    checkOutput("addr", cmd_addr, exp_addr);
    checkOutput("len", cmd_len, BL);
    applyStimulus(0, 200, 200);
    for (int i = 0; i < ready_dly; i++) begin
      @(negedge clock);
      checkOutput("valid_hold", cmd_valid, 1);
      checkOutput("port_hold", cmd_port, exp_port);
      checkOutput("write_hold", cmd_write, (exp_port == 0) ? 1 : 0);
      checkOutput("addr_hold", cmd_addr, exp_addr);
    end
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    checkOutput("valid_accepted", cmd_valid, 0);
    checkOutput("busy_busy", busy, 1);
    if (load_busy) begin
      load = 1'b1;
      @(negedge clock);
      load = 1'b0;
    end
    repeat (done_dly) @(negedge clock);
    cmd_done = 1'b1;
    @(negedge clock);
    cmd_done = 1'b0;
    checkOutput("busy_done", busy, 0);
    if (exp_port >= 0 && exp_port <= 2) modelDone(exp_port, load_busy);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rr_exp [4];
    int g, w, r1, r2;
    longint ea;

    vecs[0] = '{128, 200, 200, 1'b0, 10, 0, 0};
    vecs[1] = '{128, 200, 200, 1'b0, 0,  0, 128};
    vecs[2] = '{128, 0,   200, 1'b1, 0,  0, 256};
    vecs[3] = '{0,   0,   200, 1'b0, 1,  1, 8320};
    vecs[4] = '{127, 128, 127, 1'b0, 0,  2, 4096};
    vecs[5] = '{0,   0,   200, 1'b0, 0,  1, 8448};
    vecs[6] = '{0,   0,   200, 1'b0, 2,  1, 8320};
    vecs[7] = '{255, 200, 200, 1'b0, 0,  0, 0};

    m_base = '{0, 8320, 4096};
    m_max  = '{153600, 8576, 100000};
    driveBases();
    modelReset();
    applyStimulus(0, 200, 200);
    load = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_len", cmd_len, BL);
    checkOutput("rst_port", cmd_port, 0);
    checkOutput("rst_addr", cmd_addr, 0);
    checkOutput("rst_write", cmd_write, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      g = modelGrant(vecs[i].wr, vecs[i].rd1, vecs[i].rd2);
      doBurst(vecs[i].wr, vecs[i].rd1, vecs[i].rd2, vecs[i].exp_port, vecs[i].exp_addr,
              vecs[i].ready_dly, 1, vecs[i].load_busy);
    end

    // Reset while a burst is in flight: the burst is dropped and nothing advances.
    @(negedge clock);
    applyStimulus(128, 200, 200);
    @(negedge clock);
    @(negedge clock);
    checkOutput("mid_valid", cmd_valid, 1);
    applyStimulus(0, 200, 200);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    checkOutput("mid_busy", busy, 1);
    aresetn = 1'b0;
    @(negedge clock);
    aresetn = 1'b1;
    checkOutput("mid_rst_valid", cmd_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_addr", cmd_addr, 0);
    modelReset();
    cmd_done = 1'b1;
    @(negedge clock);
    cmd_done = 1'b0;
    checkOutput("stale_done_busy", busy, 0);
    doBurst(128, 200, 200, 0, m_base[0], 0, 0, 1'b0);

`ifdef ARB_READ_RR_EN
    rr_exp = '{1, 2, 1, 2};
`else
    rr_exp = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      g = modelGrant(0, 0, 0);
      doBurst(0, 0, 0, rr_exp[i], m_addr[rr_exp[i]], 0, 1, 1'b0);
    end

    for (int p = 0; p < 3; p++) begin
      m_base[p] = longint'($urandom_range(0, 4000)) * 4;
      m_max[p]  = m_base[p] + BL * longint'($urandom_range(1, 4)) + longint'($urandom_range(0, 127));
    end
    @(negedge clock);
    driveBases();
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    for (int p = 0; p < 3; p++) m_addr[p] = m_base[p];

    for (int n = 0; n < 40; n++) begin
      w  = int'($urandom_range(100, 200));
      r1 = int'($urandom_range(100, 200));
      r2 = int'($urandom_range(100, 200));
      if (w < BL && r1 >= BL && r2 >= BL) r2 = 5;
      g  = modelGrant(w, r1, r2);
      ea = m_addr[g];
      doBurst(w, r1, r2, g, ea, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        cmd_done = 1'b1;
        @(negedge clock);
        cmd_done = 1'b0;
        checkOutput("stray_done_busy", busy, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
